// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
// Holds the reset period, mode encodings, minimum period and timebase FSM states.
package pwm_pkg;

  localparam int unsigned PWM_DEF_PERIOD = 100000;
  localparam int unsigned PWM_MIN_PERIOD = 2;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // IDLE = counter parked at 0 while disabled; UP/DOWN = counting direction.
  typedef enum logic [1:0] {
    TB_IDLE = 2'd0,
    TB_UP   = 2'd1,
    TB_DOWN = 2'd2
  } pwm_tb_state_e;

endpackage

// File: rtl/pwm_gen_if.sv
// Host configuration bus of the PWM generator: period/mode and per-channel duty writes.
// Strobes are single-cycle write pulses with no ready: every strobe is accepted on the clock edge it is seen.
interface pwm_gen_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             period_we;
  logic [CNT_W-1:0] period_in;
  logic             mode_in;
  logic             duty_we;
  logic [CH_W-1:0]  ch_sel;
  logic [CNT_W-1:0] duty_in;

  modport master (
    output period_we, period_in, mode_in, duty_we, ch_sel, duty_in
  );

  modport slave (
    input period_we, period_in, mode_in, duty_we, ch_sel, duty_in
  );

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM counter: edge (sawtooth) or center (triangle) counting, period
// boundary detection (load strobe for active copies) and the registered period tick.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] period_i,
  input  pwm_mode_e        mode_i,
  output logic [CNT_W-1:0] count_o,
  output logic             load_o,
  output logic             cmp_en_o,
  output logic             tick_o,
  output pwm_tb_state_e    state_o
);

  pwm_tb_state_e    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] p_last;
  logic             bnd_q;
  logic             tick_q;

  // Last count value of the up ramp, i.e. max(period, 2) - 1.
  always_comb begin
    if (period_i < CNT_W'(PWM_MIN_PERIOD)) begin
      p_last = CNT_W'(PWM_MIN_PERIOD - 1);
    end else begin
      p_last = period_i - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TB_IDLE;
      count_q <= '0;
      bnd_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      bnd_q   <= load_o;
      tick_q  <= enable_i & bnd_q;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!enable_i) begin
      state_d = TB_IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        TB_IDLE: begin
          state_d = TB_UP;
          count_d = '0;
        end
        TB_UP: begin
          if (count_q == p_last) begin
            // A 2-count triangle has no down ramp: P-2 is already 0.
            if (mode_i == MODE_CENTER && p_last != CNT_W'(1)) begin
              count_d = count_q - CNT_W'(1);
              state_d = TB_DOWN;
            end else begin
              count_d = '0;
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        TB_DOWN: begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = TB_UP;
          end
        end
        default: begin
          state_d = TB_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // While running, count_d only returns to 0 on a wrap, so that marks the boundary.
  always_comb begin
    load_o   = enable_i && (state_q == TB_IDLE || count_d == '0);
    cmp_en_o = enable_i && (state_q != TB_IDLE);
    tick_o   = tick_q;
    count_o  = count_q;
    state_o  = state_q;
  end

endmodule

// File: rtl/pwm_gen.sv
// N_CH-channel PWM generator: pending/active shadow registers for period, mode
// and duties, one shared timebase, and a registered comparator per channel.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = PWM_DEF_PERIOD
) (
  input  logic            CLK100MHZ,
  input  logic            reset,
  input  logic            enable,
  pwm_gen_if.slave        cfg,
  output logic [N_CH-1:0] pwm_out,
  output logic            period_tick,
  output pwm_tb_state_e   state_dbg_o
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CNT_W-1:0] period_pend_q, period_pend_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  pwm_mode_e        mode_pend_q, mode_pend_d;
  pwm_mode_e        mode_act_q, mode_act_d;
  logic [CNT_W-1:0] count;
  logic             load;
  logic             cmp_en;

  // Active copies take the pending value as it stood before this edge, so a
  // write landing on a boundary edge waits for the next boundary.
  always_comb begin
    period_pend_d = period_pend_q;
    mode_pend_d   = mode_pend_q;
    if (cfg.period_we) begin
      period_pend_d = cfg.period_in;
      mode_pend_d   = pwm_mode_e'(cfg.mode_in);
    end
    period_act_d = load ? period_pend_q : period_act_q;
    mode_act_d   = load ? mode_pend_q : mode_act_q;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      period_pend_q <= CNT_W'(DEF_PERIOD);
      period_act_q  <= CNT_W'(DEF_PERIOD);
      mode_pend_q   <= MODE_EDGE;
      mode_act_q    <= MODE_EDGE;
    end else begin
      period_pend_q <= period_pend_d;
      period_act_q  <= period_act_d;
      mode_pend_q   <= mode_pend_d;
      mode_act_q    <= mode_act_d;
    end
  end

  pwm_timebase #(
    .CNT_W(CNT_W)
  ) u_timebase (
    .clk_i    (CLK100MHZ),
    .rst_i    (reset),
    .enable_i (enable),
    .period_i (period_act_q),
    .mode_i   (mode_act_q),
    .count_o  (count),
    .load_o   (load),
    .cmp_en_o (cmp_en),
    .tick_o   (period_tick),
    .state_o  (state_dbg_o)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_pend_q, duty_pend_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q;

    // Out-of-range channel selects match no slice and are dropped.
    always_comb begin
      duty_pend_d = duty_pend_q;
      if (cfg.duty_we && cfg.ch_sel == CH_W'(i)) begin
        duty_pend_d = cfg.duty_in;
      end
      duty_act_d = load ? duty_pend_q : duty_act_q;
    end

    always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
        duty_pend_q <= '0;
        duty_act_q  <= '0;
        pwm_q       <= 1'b0;
      end else begin
        duty_pend_q <= duty_pend_d;
        duty_act_q  <= duty_act_d;
        pwm_q       <= cmp_en && (count < duty_act_q);
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: a phase-position reference model predicts pwm_out/period_tick
// every cycle, plus directed duty-cycle and tick counts over whole periods.
module tb_pwm_gen;
  import pwm_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
  localparam int CH_W  = 2;
  localparam int W     = N_CH + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [N_CH-1:0] pwm_out;
  logic period_tick;
  pwm_tb_state_e state_dbg;

  always #5 clk = ~clk;

  pwm_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg ();

  pwm_gen #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEF_PERIOD(100000)
  ) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg         (cfg),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .state_dbg_o (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int ones[N_CH];
  int ticks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A period is a sequence of phase positions k = 0..len-1; the count seen at
  // position k follows from the period and mode alone.
  longint m_pend_period, m_act_period;
  bit     m_pend_mode, m_act_mode;
  longint m_pend_duty[N_CH];
  longint m_act_duty[N_CH];
  bit     m_run, m_new;
  longint m_k;

  function automatic longint p_eff(input longint per);
    return (per < 2) ? 2 : per;
  endfunction

  function automatic longint period_len(input longint per, input bit mode);
    return mode ? (2 * p_eff(per) - 2) : p_eff(per);
  endfunction

  function automatic longint count_at(input longint k, input longint per, input bit mode);
    if (!mode || k < p_eff(per)) return k;
    return 2 * p_eff(per) - 2 - k;
  endfunction

  task automatic model_load();
    m_act_period = m_pend_period;
    m_act_mode   = m_pend_mode;
    for (int i = 0; i < N_CH; i++) m_act_duty[i] = m_pend_duty[i];
  endtask

  task automatic model_step();
    logic [W-1:0] e;
    e = '0;
    if (reset) begin
      m_pend_period = 100000; m_act_period = 100000;
      m_pend_mode = 1'b0; m_act_mode = 1'b0;
      for (int i = 0; i < N_CH; i++) begin m_pend_duty[i] = 0; m_act_duty[i] = 0; end
      m_run = 1'b0; m_new = 1'b0; m_k = 0;
    end else begin
      e[N_CH] = enable && m_new;
      for (int i = 0; i < N_CH; i++)
        e[i] = enable && m_run && (count_at(m_k, m_act_period, m_act_mode) < m_act_duty[i]);
      if (!enable) begin
        m_run = 1'b0; m_k = 0; m_new = 1'b0;
      end else if (!m_run || (m_k + 1 == period_len(m_act_period, m_act_mode))) begin
        m_run = 1'b1; m_k = 0; m_new = 1'b1;
        model_load();
      end else begin
        m_k++; m_new = 1'b0;
      end
      if (cfg.period_we) begin
        m_pend_period = longint'(cfg.period_in);
        m_pend_mode   = cfg.mode_in;
      end
      if (cfg.duty_we && int'(cfg.ch_sel) < N_CH) m_pend_duty[cfg.ch_sel] = longint'(cfg.duty_in);
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [W-1:0] got, e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    got = {period_tick, pwm_out};
    e = exp_q.pop_front();
    check("out", 32'(got), 32'(e));
    for (int i = 0; i < N_CH; i++) ones[i] += int'(pwm_out[i]);
    ticks += int'(period_tick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_period(input int p, input bit m);
    cfg.period_we = 1'b1; cfg.period_in = CNT_W'(p); cfg.mode_in = m;
    step();
    cfg.period_we = 1'b0;
  endtask

  task automatic write_duty(input int ch, input int d);
    cfg.duty_we = 1'b1; cfg.ch_sel = CH_W'(ch); cfg.duty_in = CNT_W'(d);
    step();
    cfg.duty_we = 1'b0;
  endtask

  int s_ones[N_CH];
  int s_ticks;

  task automatic snap();
    for (int i = 0; i < N_CH; i++) s_ones[i] = ones[i];
    s_ticks = ticks;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; enable = 1'b0;
    cfg.period_we = 1'b0; cfg.period_in = '0; cfg.mode_in = 1'b0;
    cfg.duty_we = 1'b0; cfg.ch_sel = '0; cfg.duty_in = '0;
    for (int i = 0; i < N_CH; i++) ones[i] = 0;
    run(3);
    check("reset_outputs", 32'({period_tick, pwm_out}), 0);
    reset = 1'b0;
    run(2);

    // defaults, ch0 duty 5000 of 100000
    write_duty(0, 5000);
    enable = 1'b1;
    snap();
    run(5100);
    check("def_ch0_high", 32'(ones[0] - s_ones[0]), 5000);
    check("def_ticks", 32'(ticks - s_ticks), 1);

    // edge mode, period 10
    enable = 1'b0; run(2);
    write_period(10, 1'b0);
    write_duty(1, 3); write_duty(2, 0); write_duty(3, 15);
    enable = 1'b1; run(2);
    snap(); run(30);
    check("edge_ch1_high", 32'(ones[1] - s_ones[1]), 9);
    check("edge_ch2_low", 32'(ones[2] - s_ones[2]), 0);
    check("edge_ch3_high", 32'(ones[3] - s_ones[3]), 30);
    check("edge_ticks", 32'(ticks - s_ticks), 3);

    // center mode, period 6 -> 10 clocks, 3 high
    enable = 1'b0; run(1);
    write_period(6, 1'b1);
    write_duty(0, 2);
    enable = 1'b1; run(2);
    snap(); run(30);
    check("center_ch0_high", 32'(ones[0] - s_ones[0]), 9);
    check("center_ticks", 32'(ticks - s_ticks), 3);

    // duty change mid-period and on a boundary edge
    enable = 1'b0; run(1);
    write_period(10, 1'b0);
    write_duty(0, 4);
    enable = 1'b1; run(4);
    write_duty(0, 7);
    for (int g = 0; g < 20 && m_k != 9; g++) step();
    check("sync_last_phase", 32'(m_k), 9);
    write_duty(0, 2);
    snap(); run(10);
    check("dutychg_next", 32'(ones[0] - s_ones[0]), 7);
    snap(); run(10);
    check("dutychg_deferred", 32'(ones[0] - s_ones[0]), 2);

    // period 1 and 0 clamp to 2
    write_period(1, 1'b0);
    run(12);
    snap(); run(20);
    check("p1_ticks", 32'(ticks - s_ticks), 10);
    check("p1_ch0_high", 32'(ones[0] - s_ones[0]), 20);
    write_period(0, 1'b0);
    run(12);
    snap(); run(20);
    check("p0_ticks", 32'(ticks - s_ticks), 10);

    // enable dropped mid-period, then re-enabled
    write_period(10, 1'b0);
    run(13);
    enable = 1'b0; step();
    check("disable_outputs", 32'({period_tick, pwm_out}), 0);
    step();
    enable = 1'b1; step(); step();
    check("reenable_tick", 32'(period_tick), 1);

    // reset mid-period
    run(5);
    reset = 1'b1; step();
    check("midreset_outputs", 32'({period_tick, pwm_out}), 0);
    reset = 1'b0;
    snap(); run(20);
    check("midreset_ticks", 32'(ticks - s_ticks), 1);
    check("midreset_duty0", 32'(ones[0] - s_ones[0]), 0);

    // randomized traffic
    write_period(8, 1'b1);
    for (int n = 0; n < 1500; n++) begin
      cfg.period_we = ($urandom_range(0, 9) == 0);
      cfg.period_in = CNT_W'($urandom_range(0, 12));
      cfg.mode_in   = 1'($urandom_range(0, 1));
      cfg.duty_we   = ($urandom_range(0, 3) == 0);
      cfg.ch_sel    = CH_W'($urandom_range(0, N_CH - 1));
      cfg.duty_in   = CNT_W'($urandom_range(0, 14));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    cfg.period_we = 1'b0; cfg.duty_we = 1'b0; reset = 1'b0;
    run(3);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
